// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency WxW multiplier among N requesters.
// A LAT-deep tag pipeline tracks the owner of each product to the tagged response port.
module mult_rr_sched #(
  parameter int unsigned W   = 8,
  parameter int unsigned N   = 4,
  parameter int unsigned LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req_valid,
  output logic [N-1:0]             req_ready,
  input  logic [N*W-1:0]           req_a,
  input  logic [N*W-1:0]           req_b,
  output logic [W-1:0]             mul_a,
  output logic [W-1:0]             mul_b,
  input  logic [2*W-1:0]           mul_p,
  output logic                     rsp_valid,
  output logic [$clog2(N)-1:0]     rsp_id,
  output logic [2*W-1:0]           rsp_p
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned PW  = 2 * W;

  logic [IDW-1:0] last;
  logic           grant_vld;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand;

  logic [LAT-1:0] tag_valid;
  logic [IDW-1:0] tag_id [LAT];

  // Search from last+1 (mod N); first valid requester wins, operands follow the grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = IDW'((32'(last) + off) % N);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_vld) begin
      req_ready[grant_idx] = 1'b1;
      mul_a = req_a[32'(grant_idx) * W +: W];
      mul_b = req_b[32'(grant_idx) * W +: W];
    end
  end

  // Reset pointer to N-1 so requester 0 has top priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= IDW'(N - 1);
    end else if (grant_vld) begin
      last <= grant_idx;
    end
  end

  // Tag pipeline mirrors the multiplier depth; it never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid <= '0;
      for (int unsigned i = 0; i < LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_valid[0] <= grant_vld;
      tag_id[0]    <= grant_vld ? grant_idx : '0;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  // Response register: id/product hold between valid strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
    end else begin
      rsp_valid <= tag_valid[LAT-1];
      if (tag_valid[LAT-1]) begin
        rsp_id <= tag_id[LAT-1];
        rsp_p  <= PW'(mul_p);
      end
    end
  end

endmodule

// File: doc/mult_rr_sched.md
# mult_rr_sched

Round-robin scheduler that shares one fixed-latency W×W multiplier among N requesters. It grants at most one request per cycle, drives the granted operands onto the multiplier inputs, and tracks the requester ID through a LAT-deep tag pipeline. It returns each product to the requester on a tagged, registered response port. It sits between client blocks and the multiplier instance, which has registered inputs, a registered output and no reset.

## Interface
- W, 8: operand width; product width 2W.
- N, 4: number of requesters, 2..16; IDW = $clog2(N).
- LAT, 2: multiplier latency in edges, from the edge that latches operands to the edge that registers the product; ≥1.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N  request i presents operands.
- req_ready  out  N  one-hot grant; transfer when req_valid[i] & req_ready[i] at a rising edge.
- req_a  in  N*W  operand A of requester i in bits [i*W +: W].
- req_b  in  N*W  operand B of requester i in bits [i*W +: W].
- mul_a  out  W  to multiplier dA.
- mul_b  out  W  to multiplier dB.
- mul_p  in  2W  from multiplier a_mult_b.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  IDW  requester owning rsp_p.
- rsp_p  out  2W  unsigned product req_a*req_b.

## Operation
- Arbitration is combinational, round-robin.
  - Pointer `last` (IDW bits) holds the last granted index.
  - The search starts at last+1 and wraps modulo N.
  - The first i with req_valid[i] receives req_ready[i]=1.
  - All other bits of req_ready are 0.
  - If no request is valid, req_ready=0.
- req_ready[i] depends only on req_valid and `last`. It never depends on operand values.
- Operand mux:
  - When a grant is active, mul_a/mul_b = the granted requester's req_a/req_b.
  - When no grant is active, mul_a/mul_b = 0.
- On each edge with a grant:
  - `last` ← granted index.
  - Tag stage 0 ← {valid=1, id=granted index}.
- On each edge without a grant, tag stage 0 ← {0, 0}.
- Tag pipeline: stages 0..LAT-1 shift every edge, with no stall. The multiplier never stalls.
- Response register, updated every edge:
  - rsp_valid ← tag[LAT-1].valid.
  - When tag[LAT-1].valid = 1: rsp_id ← tag[LAT-1].id and rsp_p ← mul_p.
  - When tag[LAT-1].valid = 0: rsp_id and rsp_p hold their previous value.
- There is no response back-pressure. Consumers filter on rsp_id and must sample the cycle rsp_valid is high.
- Requester obligations:
  - While req_valid[i]=1 and the request is not yet accepted, req_a/req_b of that requester are held stable.
  - req_valid[i] is not withdrawn before acceptance.
- Arithmetic is unsigned, full width 2W, with no truncation or overflow. Example: 255*255 = 65025 at W=8.

## Timing
- Reset values, applied asynchronously on rst=1:
  - `last` = N-1, so requester 0 has top priority after reset.
  - All tags are invalid.
  - rsp_valid=0, rsp_id=0, rsp_p=0.
- req_ready, mul_a and mul_b follow their combinational rules during reset. Grants issued while rst=1 are not recorded.
- Latency: a request accepted at edge k gives rsp_valid=1 during the cycle after edge k+LAT. For LAT=2 that is 3 edges inclusive of the accept edge.
- Throughput is one request per cycle. Back-to-back grants yield back-to-back responses in grant order.
- Fairness: a requester holding req_valid waits at most N-1 grants.
- Reset mid-operation:
  - All in-flight tags are dropped, so no rsp_valid occurs for them.
  - The multiplier's unreset contents are ignored.
  - The first post-reset grant goes to the lowest-index valid requester.
- Simultaneous events:
  - A newly valid requester entering alongside others is served in pointer order.
  - A requester re-requesting right after its own grant drops to lowest priority.
- Wrap-around: after a grant to index N-1, the search starts at 0.

## Test plan
- Reset, then a single request from requester 2 with a=7, b=9, accepted at edge k → rsp_valid=1, rsp_id=2, rsp_p=63 in the cycle after edge k+LAT. No other rsp_valid.
- All four requesters valid continuously for 8 cycles, after reset → grant order 0,1,2,3,0,1,2,3. Responses arrive back-to-back in the same order with correct products.
- Requesters 1 and 3 valid, with 3 re-requesting immediately after its grant → grants alternate 1,3,1,3. Neither waits more than one grant.
- Operand corners a=255,b=255, a=0,b=200 and a=1,b=128 → rsp_p = 65025, 0 and 128 respectively.
- rst asserted asynchronously mid-cycle with 2 requests in flight → rsp_valid drops at once and the in-flight results never appear. After release, requester 0 wins a 0-vs-3 tie.
- Idle pipeline bubbles, with grants on cycles 0, 2 and 3 → rsp_valid pattern 1,0,1,1 delayed by LAT+1 edges. rsp_id and rsp_p hold their value during the gap.
